data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Memory-side responder for Memory-stage load/store requests. Latches one request per
//  valid/ready handshake, inserts programmable wait states, then performs a byte/half/word
//  access on internal word-organised RAM. Returns sign- or zero-extended load data with an
//  error flag on a valid/ready response channel. One access in flight; no pipelining.
// PARAMETERS
//  DEPTH_WORDS  1024  RAM depth in 32-bit words (power of 2, >=2)
//  WAIT_STATES  1     extra cycles between accept and access (0..15)
// PORTS
//  clk            in   1   clock, rising edge
//  rst            in   1   synchronous reset, active-high
//  req_valid      in   1   request present
//  req_ready      out  1   responder can accept request
//  req_we         in   1   1=store, 0=load
//  req_addr       in   32  byte address
//  req_wdata      in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//  req_size       in   2   00=byte 01=half 10=word 11=illegal
//  req_unsigned   in   1   load only: 1=zero-extend, 0=sign-extend
//  rsp_valid      out  1   response present
//  rsp_ready      in   1   consumer takes response
//  rsp_rdata      out  32  load data (0 for stores and errors)
//  rsp_err        out  1   misaligned, illegal size or out-of-range access
// BEHAVIOUR
//  Reset: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
//   RAM contents are not cleared.
//  FSM IDLE -> WAIT -> RESP -> IDLE.
//   IDLE: req_ready=1. req_valid=1 on an edge: latch we/addr/wdata/size/unsigned,
//    load counter=WAIT_STATES, go to WAIT. No accept in WAIT or RESP (req_ready=0).
//   WAIT: counter!=0 -> decrement. counter==0 -> perform access, register rsp_rdata/rsp_err,
//    go to RESP.
//   RESP: rsp_valid=1. rsp_rdata/rsp_err held stable until rsp_ready=1 on an edge, then IDLE.
//    No new request is accepted in the same cycle as the response handshake.
//  Latency: rsp_valid rises WAIT_STATES+1 clocks after the accept edge.
//  Addressing: word index = addr[31:2]. Out of range when addr[31:2] >= DEPTH_WORDS.
//  Errors: size==11, half with addr[0]=1, word with addr[1:0]!=0, or out of range.
//   Each sets rsp_err=1 and rsp_rdata=0. No RAM write is performed.
//  Store byte enables: byte -> lane addr[1:0], data wdata[7:0].
//   Half -> lanes {addr[1],0} and {addr[1],1}, data wdata[15:0]. Word -> all lanes.
//   Other lanes are unchanged. Store response: rsp_rdata=0.
//  Load: select the byte or half lane by addr[1:0]. Extend to 32 bits per req_unsigned.
//   req_unsigned is ignored for word loads.
//  Write commit: RAM is written only on the WAIT->RESP edge.
//  Reset in WAIT: drops the request and no write occurs.
//  Reset in RESP: drops the pending response; an already-committed write is kept.
// TESTING
//  1 Reset, then poll outputs -> req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
//  2 WAIT_STATES=1: store word 0xDEADBEEF @0x10, then load word @0x10 -> rdata=0xDEADBEEF.
//    rsp_valid rises 2 clocks after each accept.
//  3 Store byte 0x80 @0x11 over 0x00000000, then:
//    load word @0x10 -> 0x00008000; load byte signed @0x11 -> 0xFFFFFF80;
//    load byte unsigned @0x11 -> 0x00000080.
//  4 Load half @0x13 -> rsp_err=1, rdata=0. Store word @0x4000 with DEPTH=1024 -> rsp_err=1,
//    and a later read of word 0 shows no change.
//  5 Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and data stable,
//    req_ready=0. Release -> IDLE next cycle.
//  6 Assert rst during WAIT of a store of 0x12345678 @0x20 -> IDLE next edge.
//    A later load @0x20 returns the old value.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Memory-side responder for load/store requests. One request is accepted per
//   valid/ready handshake. It then sits in a programmable number of wait states
//   before doing a byte, half or word access on an internal word-organised RAM.
//   The response comes back on a valid/ready channel. It carries load data that
//   is sign- or zero-extended, plus an error flag. Only one access is in flight.
//
// Parameters
//   DEPTH_WORDS  RAM depth in 32-bit words (power of 2, >= 2)
//   WAIT_STATES  extra cycles between accept and access (0..15)
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous reset, active-high
//   req_valid     request present
//   req_ready     responder can accept a request (IDLE only)
//   req_we        1 = store, 0 = load
//   req_addr      byte address
//   req_wdata     store data, right-aligned
//   req_size      00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned  loads: 1 zero-extends, 0 sign-extends (ignored for words)
//   rsp_valid     response present (RESP only)
//   rsp_ready     consumer takes the response
//   rsp_rdata     load data (0 for stores and errors)
//   rsp_err       misaligned, illegal size or out-of-range access

module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);
  localparam logic [31:0] DEPTH_LIM = 32'(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } stateT;

  stateT       stateReg, stateNext;
  logic [3:0]  cntReg, cntNext;
  logic        accept;
  logic        commit;

  // Request captured at accept
  logic        weReg;
  logic [31:0] addrReg;
  logic [31:0] wdataReg;
  logic [1:0]  sizeReg;
  logic        unsReg;

  // Response registers
  logic [31:0] rdataReg;
  logic        errReg;

  // Access decode
  logic        sizeIllegal;
  logic        misaligned;
  logic        outOfRange;
  logic        accErr;
  logic        ramWe;
  logic [AW-1:0] rdIdx;
  logic [AW-1:0] wrIdx;
  logic [31:0] rdWord;
  logic [7:0]  byteSel;
  logic [15:0] halfSel;
  logic [31:0] loadData;
  logic [31:0] rdataNext;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    stateNext = stateReg;
    cntNext   = cntReg;
    accept    = 1'b0;
    commit    = 1'b0;
    case (stateReg)
      IDLE: begin
        if (req_valid) begin
          accept    = 1'b1;
          cntNext   = WAIT_INIT;
          stateNext = WAIT;
        end
      end
      WAIT: begin
        if (cntReg != 4'd0) begin
          cntNext = cntReg - 4'd1;
        end else begin
          commit    = 1'b1;
          stateNext = RESP;
        end
      end
      RESP: begin
        // Always return to IDLE. This means a new request can never be
        // accepted in the same cycle as the response handshake.
        if (rsp_ready) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign req_ready = (stateReg == IDLE);
  assign rsp_valid = (stateReg == RESP);
  assign rsp_rdata = rdataReg;
  assign rsp_err   = errReg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg <= IDLE;
      cntReg   <= 4'd0;
      weReg    <= 1'b0;
      addrReg  <= 32'd0;
      wdataReg <= 32'd0;
      sizeReg  <= 2'd0;
      unsReg   <= 1'b0;
      rdataReg <= 32'd0;
      errReg   <= 1'b0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
      if (accept) begin
        weReg    <= req_we;
        addrReg  <= req_addr;
        wdataReg <= req_wdata;
        sizeReg  <= req_size;
        unsReg   <= req_unsigned;
      end
      if (commit) begin
        rdataReg <= rdataNext;
        errReg   <= accErr;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Error decode on the latched request
  // ---------------------------------------------------------------------------
  always_comb begin
    sizeIllegal = (sizeReg == 2'b11);
    misaligned  = ((sizeReg == 2'b01) && addrReg[0]) ||
                  ((sizeReg == 2'b10) && (addrReg[1:0] != 2'b00));
    outOfRange  = ({2'b00, addrReg[31:2]} >= DEPTH_LIM);
    accErr      = sizeIllegal || misaligned || outOfRange;
  end

  // An erroring store never touches the RAM. A reset arriving on the commit
  // edge also suppresses the write, because that request is being dropped.
  assign ramWe = commit && weReg && !accErr && !rst;
  assign wrIdx = addrReg[AW+1:2];

  // The read port is registered. In IDLE it follows the incoming address, so the
  // word is already in the read register on the first WAIT cycle, even when
  // WAIT_STATES is 0. Afterwards it keeps re-reading the latched address.
  assign rdIdx = (stateReg == IDLE) ? req_addr[AW+1:2] : addrReg[AW+1:2];

  // ---------------------------------------------------------------------------
  // RAM: one byte-wide array per lane, so that byte enables map onto
  // independent write ports.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 4; gi++) begin : gLane
    localparam logic [1:0] LANE = 2'(gi);

    logic [7:0] ram [DEPTH_WORDS];
    logic [7:0] rdLaneReg;
    logic       laneWe;
    logic [7:0] laneWdata;

    always_comb begin
      laneWe    = 1'b0;
      laneWdata = wdataReg[8*gi +: 8];
      case (sizeReg)
        2'b00: begin
          laneWe    = (addrReg[1:0] == LANE);
          laneWdata = wdataReg[7:0];
        end
        2'b01: begin
          // A half-word uses lanes {addr[1],0} and {addr[1],1}. Lane parity
          // picks the low or the high byte of wdata[15:0].
          laneWe    = (addrReg[1] == LANE[1]);
          laneWdata = wdataReg[8*(gi%2) +: 8];
        end
        2'b10: begin
          laneWe    = 1'b1;
          laneWdata = wdataReg[8*gi +: 8];
        end
        default: begin
          laneWe    = 1'b0;
          laneWdata = wdataReg[8*gi +: 8];
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (ramWe && laneWe) begin
        ram[wrIdx] <= laneWdata;
      end
      rdLaneReg <= ram[rdIdx];
    end

    assign rdWord[8*gi +: 8] = rdLaneReg;
  end

  // ---------------------------------------------------------------------------
  // Load lane select and extension
  // ---------------------------------------------------------------------------
  always_comb begin
    byteSel = rdWord[{addrReg[1:0], 3'b000} +: 8];
    halfSel = addrReg[1] ? rdWord[31:16] : rdWord[15:0];
    case (sizeReg)
      2'b00:   loadData = unsReg ? {24'd0, byteSel} : {{24{byteSel[7]}}, byteSel};
      2'b01:   loadData = unsReg ? {16'd0, halfSel} : {{16{halfSel[15]}}, halfSel};
      default: loadData = rdWord;
    endcase
    rdataNext = (accErr || weReg) ? 32'd0 : loadData;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
//   Directed and randomised load/store traffic against data_mem_responder. The
//   expected results come from a byte-addressed reference memory kept in the
//   bench. Each check counts as one comparison. A failed check is reported with
//   a FAIL line.

module tb_data_mem_responder;

  localparam int DEPTH = 1024;
  localparam int WS    = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int ncmp = 0;
  int nfail = 0;

  logic [7:0] mdl [0:4*DEPTH-1];

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: applies the access to the byte memory and returns the
  // expected response.
  task automatic ref_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [1:0] size, input logic uns,
                            output logic [31:0] er, output logic ee);
    int n;
    logic [31:0] v;
    n  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    ee = (size == 2'd3) || ((addr % n) != 0) || ((addr / 4) >= DEPTH);
    er = 32'd0;
    if (ee) return;
    if (we) begin
      for (int i = 0; i < n; i++) mdl[addr + i] = 8'(wdata >> (8 * i));
    end else begin
      v = 32'd0;
      for (int i = 0; i < n; i++) v = v | (32'(mdl[addr + i]) << (8 * i));
      if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
      er = v;
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns);
    req_valid = 1'b1; req_we = we; req_addr = addr;
    req_wdata = wdata; req_size = size; req_unsigned = uns;
  endtask

  // One full transaction: accept, latency, response, bp cycles of
  // backpressure, handshake (with a competing request held up), back to IDLE.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [1:0] size, input logic uns, input int bp,
                     input string tag, output logic [31:0] got);
    logic [31:0] er;
    logic ee;
    int lat;
    ref_access(we, addr, wdata, size, uns, er, ee);
    got = 32'hxxxxxxxx;
    @(negedge clk);
    check({tag, "/req_ready"}, 32'(req_ready), 32'd1);
    drive(we, addr, wdata, size, uns);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "/latency"}, 32'(lat), 32'(WS + 1));
    if (rsp_valid) begin
      got = rsp_rdata;
      $display("txn %s we=%0d addr=%h wdata=%h size=%0d uns=%0d -> rdata=%h err=%0d",
               tag, we, addr, wdata, size, uns, rsp_rdata, rsp_err);
      check({tag, "/rdata"}, rsp_rdata, er);
      check({tag, "/err"}, 32'(rsp_err), 32'(ee));
      for (int c = 0; c < bp; c++) begin
        @(posedge clk); #1;
        check({tag, "/bp_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "/bp_rdata"}, rsp_rdata, er);
        check({tag, "/bp_err"}, 32'(rsp_err), 32'(ee));
        check({tag, "/bp_req_ready"}, 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      drive(1'b0, 32'd0, 32'd0, 2'd2, 1'b0);
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      req_valid = 1'b0;
      check({tag, "/idle_ready"}, 32'(req_ready), 32'd1);
      check({tag, "/idle_valid"}, 32'(rsp_valid), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] er;
    logic        ee;
    int          lat;
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    int          sel;

    // 1: reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset/req_ready", 32'(req_ready), 32'd1);
    check("reset/rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset/rsp_rdata", rsp_rdata, 32'd0);
    check("reset/rsp_err", 32'(rsp_err), 32'd0);

    // Give words 0..31 known contents
    for (int w = 0; w < 32; w++) begin
      txn(1'b1, 32'(w * 4), $urandom, 2'd2, 1'b0, 0, "init", got);
    end

    // 2: word store and load back
    txn(1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, 0, "t2_st", got);
    txn(1'b0, 32'h10, 32'd0, 2'd2, 1'b0, 0, "t2_ld", got);
    check("t2/const", got, 32'hDEADBEEF);

    // 3: byte store, then load word, signed byte and unsigned byte
    txn(1'b1, 32'h10, 32'h0, 2'd2, 1'b0, 0, "t3_clr", got);
    txn(1'b1, 32'h11, 32'h80, 2'd0, 1'b0, 0, "t3_sb", got);
    txn(1'b0, 32'h10, 32'd0, 2'd2, 1'b0, 0, "t3_lw", got);
    check("t3/lw_const", got, 32'h00008000);
    txn(1'b0, 32'h11, 32'd0, 2'd0, 1'b0, 0, "t3_lb", got);
    check("t3/lb_const", got, 32'hFFFFFF80);
    txn(1'b0, 32'h11, 32'd0, 2'd0, 1'b1, 0, "t3_lbu", got);
    check("t3/lbu_const", got, 32'h00000080);

    // 4: misaligned half, out-of-range store that must not alias into word 0
    txn(1'b0, 32'h13, 32'd0, 2'd1, 1'b0, 0, "t4_mis", got);
    txn(1'b1, 32'h4000, 32'hA5A5A5A5, 2'd2, 1'b0, 0, "t4_oor", got);
    txn(1'b0, 32'h0, 32'd0, 2'd2, 1'b0, 0, "t4_w0", got);

    // 5: five cycles of backpressure on a load
    txn(1'b0, 32'h10, 32'd0, 2'd2, 1'b0, 5, "t5_bp", got);

    // 6: reset during WAIT drops the store
    @(negedge clk);
    check("t6/req_ready", 32'(req_ready), 32'd1);
    drive(1'b1, 32'h20, 32'h12345678, 2'd2, 1'b0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t6/idle_ready", 32'(req_ready), 32'd1);
    check("t6/idle_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    check("t6/no_resp", 32'(rsp_valid), 32'd0);
    txn(1'b0, 32'h20, 32'd0, 2'd2, 1'b0, 0, "t6_ld", got);

    // Reset during RESP keeps the write that was already committed
    ref_access(1'b1, 32'h24, 32'hCAFEF00D, 2'd2, 1'b0, er, ee);
    @(negedge clk);
    drive(1'b1, 32'h24, 32'hCAFEF00D, 2'd2, 1'b0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("t7/latency", 32'(lat), 32'(WS + 1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t7/idle_valid", 32'(rsp_valid), 32'd0);
    txn(1'b0, 32'h24, 32'd0, 2'd2, 1'b0, 0, "t7_ld", got);

    // Randomised traffic over words 0..31, with occasional illegal sizes and
    // out-of-range addresses that would alias into that region
    for (int k = 0; k < 60; k++) begin
      we   = 1'($urandom_range(0, 1));
      sel  = int'($urandom_range(0, 9));
      addr = 32'($urandom_range(0, 127));
      if (sel == 0) addr = 32'(32'h1000 * $urandom_range(1, 8)) + addr;
      size = (sel == 1) ? 2'd3 : 2'($urandom_range(0, 2));
      if (sel > 4) begin
        if (size == 2'd1) addr = addr & ~32'd1;
        if (size == 2'd2) addr = addr & ~32'd3;
      end
      txn(we, addr, $urandom, size, 1'($urandom_range(0, 1)),
          int'($urandom_range(0, 2)), "rand", got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
